// File: rtl/param_updown_counter_pkg.sv
// Shared definitions for the parametrised up/down counter and the timer blocks reusing it.
// Latency: none (definitions only).
// Backpressure: none.
// Contents: direction encodings, default WIDTH/INIT, per-edge operation select.
// Optional feature macro used by the counter: COUNTER_MODULO_EN.

`ifndef COUNTER_DEFS_SVH
`define COUNTER_DEFS_SVH
`define COUNTER_DIR_UP 1'b1
`define COUNTER_DIR_DN 1'b0
`endif

package param_updown_counter_pkg;

    localparam int DEFAULT_WIDTH = 9;
    localparam int DEFAULT_INIT  = 0;

    // What the counter does on a given edge, after priority resolution.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_COUNT = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLR   = 2'd3
    } op_e;

    // clr beats load, load beats count.
    function automatic op_e sel_op(input logic clr, input logic ld_en, input logic en);
        if (clr) begin
            return OP_CLR;
        end else if (ld_en) begin
            return OP_LOAD;
        end else if (en) begin
            return OP_COUNT;
        end
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/param_updown_counter_if.sv
// Control/status bundle of the up/down counter.
// Latency: none (wiring only).
// Backpressure: none; controls are sampled every edge.
// Ports: master drives clr/ldEn/parIn/en/up/ovfClr (and maxVal with COUNTER_MODULO_EN);
//        slave (the counter) drives parOut/cOut/tc/ovf.

interface param_updown_counter_if #(
    parameter int WIDTH = param_updown_counter_pkg::DEFAULT_WIDTH
);
    logic             clr;
    logic             ldEn;
    logic [WIDTH-1:0] parIn;
    logic             en;
    logic             up;
    logic             ovfClr;
`ifdef COUNTER_MODULO_EN
    logic [WIDTH-1:0] maxVal;
`endif
    logic [WIDTH-1:0] parOut;
    logic             cOut;
    logic             tc;
    logic             ovf;

    modport master (
`ifdef COUNTER_MODULO_EN
        output maxVal,
`endif
        output clr, ldEn, parIn, en, up, ovfClr,
        input  parOut, cOut, tc, ovf
    );

    modport slave (
`ifdef COUNTER_MODULO_EN
        input  maxVal,
`endif
        input  clr, ldEn, parIn, en, up, ovfClr,
        output parOut, cOut, tc, ovf
    );
endinterface

// File: rtl/counter_next_value.sv
// Next count and wrap bit for one up or down step against a wrap limit.
// Latency: combinational.
// Backpressure: none.
// Ports: cnt (current count), up (direction), top (wrap limit) -> nxt, wrap.

module counter_next_value #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             up,
    input  logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap
);
    logic             carry_up;
    logic [WIDTH-1:0] unused_diff_lo;
    logic [WIDTH-1:0] inc;
    logic [WIDTH:0]   dec;
    logic             borrow_dn;

    // cnt + ~top + 1 = cnt - top; the carry-out is set exactly when cnt >= top.
    // With top all ones this is the plain carry out of cnt + 1, so one adder
    // serves both the binary and the modulo build.
    assign {carry_up, unused_diff_lo} = {1'b0, cnt} + {1'b0, ~top} + (WIDTH+1)'(1);

    assign inc = cnt + WIDTH'(1);

    // Borrow out of cnt - 1 is set only when cnt is zero.
    assign dec       = {1'b0, cnt} - (WIDTH+1)'(1);
    assign borrow_dn = dec[WIDTH];

    always_comb begin
        nxt  = inc;
        wrap = 1'b0;
        if (up) begin
            wrap = carry_up;
            nxt  = carry_up ? '0 : inc;
        end else begin
            wrap = borrow_dn;
            nxt  = borrow_dn ? top : dec[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/param_updown_counter.sv
// Loadable up/down event counter with wrap pulse, terminal count and sticky overflow.
// Latency: parOut/cOut/ovf update on the sampling edge; tc is combinational from parOut/up.
// Backpressure: none; en simply stalls the count.
// Ports: clk, rst (async, active low), bus (param_updown_counter_if.slave).
// Optional feature macro: COUNTER_MODULO_EN -- wrap at bus.maxVal instead of all ones.

module param_updown_counter #(
    parameter int WIDTH = param_updown_counter_pkg::DEFAULT_WIDTH,
    parameter int INIT  = param_updown_counter_pkg::DEFAULT_INIT
) (
    input logic                    clk,
    input logic                    rst,
    param_updown_counter_if.slave  bus
);
    import param_updown_counter_pkg::*;

    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] top_val;
    logic             wrap;
    logic             cout_q;
    logic             cout_d;
    logic             ovf_q;
    logic             ovf_d;
    op_e              op;

`ifdef COUNTER_MODULO_EN
    // A new limit is picked up on the very next edge.
    assign top_val = bus.maxVal;
`else
    assign top_val = '1;
`endif

    counter_next_value #(
        .WIDTH (WIDTH)
    ) u_next (
        .cnt  (cnt_q),
        .up   (bus.up),
        .top  (top_val),
        .nxt  (cnt_nxt),
        .wrap (wrap)
    );

    assign op = sel_op(bus.clr, bus.ldEn, bus.en);

    always_comb begin
        cnt_d  = cnt_q;
        cout_d = 1'b0;
        ovf_d  = ovf_q;
        case (op)
            OP_CLR: begin
                // ovfClr is irrelevant here: clear already drops ovf.
                cnt_d = INIT_V;
                ovf_d = 1'b0;
            end
            OP_LOAD: begin
                cnt_d = bus.parIn;
                if (bus.ovfClr) begin
                    ovf_d = 1'b0;
                end
            end
            OP_COUNT: begin
                cnt_d  = cnt_nxt;
                cout_d = wrap;
                // A wrap in the same cycle as ovfClr keeps the flag set.
                ovf_d  = wrap | (ovf_q & ~bus.ovfClr);
            end
            default: begin
                if (bus.ovfClr) begin
                    ovf_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= INIT_V;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.parOut = cnt_q;
    assign bus.cOut   = cout_q;
    assign bus.ovf    = ovf_q;
    assign bus.tc     = (bus.up == `COUNTER_DIR_UP) ? (cnt_q == top_val) : (cnt_q == '0);
endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter: directed cases, then randomized traffic
// against an integer reference model. Works with or without COUNTER_MODULO_EN.

module tb_param_updown_counter;

    localparam int W    = 9;
    localparam int INIT = 0;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state
    int m_cnt;
    bit m_cout;
    bit m_ovf;

    param_updown_counter_if #(.WIDTH(W)) bus ();

    param_updown_counter #(
        .WIDTH (W),
        .INIT  (INIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int model_top();
`ifdef COUNTER_MODULO_EN
        return int'(bus.maxVal);
`else
        return MASK;
`endif
    endfunction

    // One clock edge of the counter, written from the behavioural rules.
    task automatic model_edge();
        int  top;
        bit  w;
        top = model_top();
        w   = 1'b0;
        if (bus.clr) begin
            m_cnt  = INIT;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (bus.ldEn) begin
            m_cnt  = int'(bus.parIn);
            m_cout = 1'b0;
            if (bus.ovfClr) m_ovf = 1'b0;
        end else if (bus.en) begin
            if (bus.up) begin
                if (m_cnt >= top) begin
                    m_cnt = 0;
                    w     = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                if (m_cnt == 0) begin
                    m_cnt = top;
                    w     = 1'b1;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
            m_cout = w;
            if (w) m_ovf = 1'b1;
            else if (bus.ovfClr) m_ovf = 1'b0;
        end else begin
            m_cout = 1'b0;
            if (bus.ovfClr) m_ovf = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int top;
        bit exp_tc;
        top    = model_top();
        exp_tc = bus.up ? (m_cnt == top) : (m_cnt == 0);
        chk({tag, ".parOut"}, 32'(bus.parOut), 32'(m_cnt));
        chk({tag, ".cOut"},   32'(bus.cOut),   32'(m_cout));
        chk({tag, ".ovf"},    32'(bus.ovf),    32'(m_ovf));
        chk({tag, ".tc"},     32'(bus.tc),     32'(exp_tc));
    endtask

    task automatic drive(input logic c, input logic l, input logic e, input logic u,
                         input logic o, input int p);
        bus.clr    = c;
        bus.ldEn   = l;
        bus.en     = e;
        bus.up     = u;
        bus.ovfClr = o;
        bus.parIn  = p[W-1:0];
    endtask

    // Returns 1 ns after the edge so inputs can be changed away from it.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Reset pulse between edges; outputs must clear without waiting for a clock.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        m_cnt  = INIT;
        m_cout = 1'b0;
        m_ovf  = 1'b0;
        check_all(tag);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int r;
        int p;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
`ifdef COUNTER_MODULO_EN
        bus.maxVal = W'(9);
`endif
        m_cnt  = INIT;
        m_cout = 1'b0;
        m_ovf  = 1'b0;
        #12;
        check_all("reset");
        rst = 1'b1;

`ifndef COUNTER_MODULO_EN
        // Reset in the middle of counting.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 'h0A4);
        step("ld_0a4");
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        step("cnt_0a5");
        chk("at_0a5", 32'(bus.parOut), 32'h0A5);
        async_reset("rst_mid");
        chk("rst_mid_par", 32'(bus.parOut), 32'h000);
        step("first_en");
        chk("first_en_val", 32'(bus.parOut), 32'h001);

        // Up-count roll-over.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 'h1FE);
        step("ld_1fe");
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        step("up1");
        chk("up1_val", 32'(bus.parOut), 32'h1FF);
        chk("up1_tc",  32'(bus.tc),     32'h1);
        step("up2");
        chk("up2_val",  32'(bus.parOut), 32'h000);
        chk("up2_cout", 32'(bus.cOut),   32'h1);
        step("up3");
        chk("up3_val",  32'(bus.parOut), 32'h001);
        chk("up3_cout", 32'(bus.cOut),   32'h0);
        chk("up3_ovf",  32'(bus.ovf),    32'h1);

        // Down-count borrow.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        step("dn1");
        chk("dn1_val", 32'(bus.parOut), 32'h000);
        chk("dn1_tc",  32'(bus.tc),     32'h1);
        step("dn2");
        chk("dn2_val",  32'(bus.parOut), 32'h1FF);
        chk("dn2_cout", 32'(bus.cOut),   32'h1);

        // Priority: clr over load over count.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 'h055);
        step("clr_prio");
        chk("clr_prio_ovf", 32'(bus.ovf), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 'h123);
        step("ld_prio");
        chk("ld_prio_val", 32'(bus.parOut), 32'h123);

        // Wrap with ovfClr in the same cycle: set wins.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 'h1FF);
        step("ld_1ff");
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        step("wrap_ovfclr");
        chk("wrap_ovfclr_ovf", 32'(bus.ovf), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        step("ovfclr_only");
        chk("ovfclr_only_ovf", 32'(bus.ovf), 32'h0);
`else
        // Modulo-10 counting.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        step("mod_clr");
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        for (int i = 1; i <= 10; i++) begin
            step("mod_up");
            chk("mod_up_val", 32'(bus.parOut), 32'(i % 10));
            chk("mod_up_cout", 32'(bus.cOut), 32'(i == 10));
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 'h00C);
        step("mod_ld_0c");
        chk("mod_ld_val", 32'(bus.parOut), 32'h00C);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        step("mod_above");
        chk("mod_above_val",  32'(bus.parOut), 32'h000);
        chk("mod_above_cout", 32'(bus.cOut),   32'h1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        step("mod_dn");
        chk("mod_dn_val",  32'(bus.parOut), 32'h009);
        chk("mod_dn_cout", 32'(bus.cOut),   32'h1);
`endif

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            r = int'($urandom_range(0, 99));
            case ($urandom_range(0, 3))
                0:       p = 0;
                1:       p = MASK;
                default: p = int'($urandom_range(0, MASK));
            endcase
            drive(r < 3, (r >= 3) && (r < 10), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, p);
`ifdef COUNTER_MODULO_EN
            if ($urandom_range(0, 15) == 0) bus.maxVal = W'($urandom_range(0, 31));
`endif
            step("rand");
            if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
